// File: rtl/async_pkg.sv
// Shared definitions for the async operator blocks: op-name constants,
// OP/INPUT_SIZE legality check and a width helper usable in parameter context.
package async_pkg;

  typedef logic [63:0] op_name_t;

  localparam op_name_t OP_REG  = op_name_t'("reg");
  localparam op_name_t OP_IN   = op_name_t'("in");
  localparam op_name_t OP_OUT  = op_name_t'("out");
  localparam op_name_t OP_ADDI = op_name_t'("addi");
  localparam op_name_t OP_SUBI = op_name_t'("subi");
  localparam op_name_t OP_MULI = op_name_t'("muli");
  localparam op_name_t OP_ADD  = op_name_t'("add");
  localparam op_name_t OP_SUB  = op_name_t'("sub");
  localparam op_name_t OP_MUL  = op_name_t'("mul");

  typedef enum logic [3:0] {
    OPC_PASS,
    OPC_ADDI,
    OPC_SUBI,
    OPC_MULI,
    OPC_ADD,
    OPC_SUB,
    OPC_MUL,
    OPC_BAD
  } opcode_e;

  function automatic opcode_e decode_op(op_name_t op);
    case (op)
      OP_REG, OP_IN, OP_OUT: return OPC_PASS;
      OP_ADDI:               return OPC_ADDI;
      OP_SUBI:               return OPC_SUBI;
      OP_MULI:               return OPC_MULI;
      OP_ADD:                return OPC_ADD;
      OP_SUB:                return OPC_SUB;
      OP_MUL:                return OPC_MUL;
      default:               return OPC_BAD;
    endcase
  endfunction

  // Multi-operand ops take 2..3 slots; pass-through and immediate ops take exactly one.
  function automatic bit op_legal(op_name_t op, int unsigned n);
    case (decode_op(op))
      OPC_ADD, OPC_SUB, OPC_MUL: return (n >= 2) && (n <= 3);
      OPC_BAD:                   return 1'b0;
      default:                   return n == 1;
    endcase
  endfunction

  function automatic int unsigned clog2(int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multicast_fifo.sv
// Result buffer with one write port and an independent read pointer per consumer;
// an entry is retired only after every consumer has taken it.
module multicast_fifo
  import async_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTPUT_SIZE = 1,
  parameter int DEPTH       = 4,
  localparam int AW         = clog2(DEPTH),
  localparam int LW         = clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [LW-1:0]                     level,
  output logic                              full
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]             wr_reg;
  logic [AW:0]             head_reg;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [OUTPUT_SIZE-1:0]  mask_reg [DEPTH];
  logic [OUTPUT_SIZE-1:0]  ack_vec;
  logic [AW-1:0]           rd_idx [OUTPUT_SIZE];
  logic                    empty;
  logic                    head_free;

  assign level     = LW'(wr_reg - head_reg);
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign head_free = !empty && (mask_reg[head_reg[AW-1:0]] == '0);
  assign ack_r     = ack_vec;

  always_ff @(posedge clk) begin
    if (push) mem[wr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_reg   <= '0;
      head_reg <= '0;
    end else begin
      if (push)      wr_reg   <= wr_reg + PTR_ONE;
      if (head_free) head_reg <= head_reg + PTR_ONE;
    end
  end

  // A consumer's clear never targets the slot being written: full blocks the push
  // and an empty consumer cannot ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mask_reg[i] <= '0;
    end else begin
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        if (ack_vec[j]) mask_reg[rd_idx[j]][j] <= 1'b0;
      end
      if (push) mask_reg[wr_reg[AW-1:0]] <= '1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_cons
      logic [AW:0]           rd_reg;
      logic                  ack_reg;
      logic [DATA_WIDTH-1:0] dout_reg;
      logic                  grant;

      // The ack deliberately leaves a gap cycle so rd_reg settles before the next compare.
      assign grant = req_r[gi] && !ack_reg && (rd_reg != wr_reg);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ack_reg <= 1'b0;
          rd_reg  <= '0;
        end else begin
          ack_reg <= grant;
          if (ack_reg) rd_reg <= rd_reg + PTR_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (grant) dout_reg <= mem[rd_reg[AW-1:0]];
      end

      assign ack_vec[gi]                            = ack_reg;
      assign rd_idx[gi]                             = rd_reg[AW-1:0];
      assign dout[DATA_WIDTH*gi +: DATA_WIDTH]      = dout_reg;
    end
  endgenerate

endmodule

// File: rtl/async_operator_mcast.sv
// Handshaked operator: captures INPUT_SIZE operands, computes OP on them and
// multicasts each result to OUTPUT_SIZE consumers through a shared buffer.
module async_operator_mcast
  import async_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter op_name_t              OP          = op_name_t'("reg"),
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
  parameter int                    INPUT_SIZE  = 1,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [clog2(DEPTH+1)-1:0]         level
);

  localparam opcode_e OPC = decode_op(OP);

  generate
    if (!op_legal(OP, INPUT_SIZE) || (OUTPUT_SIZE < 1) || (OUTPUT_SIZE > 8) ||
        (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
      $error("async_operator_mcast: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH combination");
    end
  endgenerate

  logic [INPUT_SIZE-1:0] has_reg;
  logic [INPUT_SIZE-1:0] has_next;
  logic [INPUT_SIZE-1:0] req_l_reg;
  logic [DATA_WIDTH-1:0] opnd_reg [INPUT_SIZE];
  logic [DATA_WIDTH-1:0] din_slot [INPUT_SIZE];
  logic [DATA_WIDTH-1:0] result;
  logic                  push;
  logic                  full;

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_slot
      assign din_slot[gi] = din[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  // Full comes from registered state, so a push never bypasses a same-edge retire.
  assign push  = (&has_reg) && !full;
  assign req_l = req_l_reg;

  always_comb begin
    has_next = has_reg;
    if (push) begin
      has_next = '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (ack_l[i]) has_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_reg   <= '0;
      req_l_reg <= '0;
    end else begin
      has_reg   <= has_next;
      req_l_reg <= ~has_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (ack_l[i] && !has_reg[i]) opnd_reg[i] <= din_slot[i];
    end
  end

  always_comb begin
    result = opnd_reg[0];
    case (OPC)
      OPC_ADDI: result = opnd_reg[0] + IMMEDIATE;
      OPC_SUBI: result = opnd_reg[0] - IMMEDIATE;
      OPC_MULI: result = opnd_reg[0] * IMMEDIATE;
      OPC_ADD: begin
        for (int i = 1; i < INPUT_SIZE; i++) result = result + opnd_reg[i];
      end
      OPC_SUB: begin
        for (int i = 1; i < INPUT_SIZE; i++) result = result - opnd_reg[i];
      end
      OPC_MUL: begin
        for (int i = 1; i < INPUT_SIZE; i++) result = result * opnd_reg[i];
      end
      default: result = opnd_reg[0];
    endcase
  end

  multicast_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .DEPTH       (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (result),
    .req_r (req_r),
    .ack_r (ack_r),
    .dout  (dout),
    .level (level),
    .full  (full)
  );

endmodule

// File: tb/tb_async_operator_mcast.sv
// Bench: an addi multicast instance checked against per-consumer expected queues,
// plus add/sub/mul instances sharing one operand feed for arithmetic corner cases.
module tb_async_operator_mcast;
  import async_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // addi +2, one operand, two consumers, DEPTH 4
  logic [0:0]  req_l_a, ack_l_a;
  logic [31:0] din_a;
  logic [1:0]  req_r_a, ack_r_a;
  logic [63:0] dout_a;
  logic [2:0]  level_a;

  // add/sub/mul instances share operand slots; each has one always-requesting consumer
  logic [2:0]  ack_bcd;
  logic [95:0] din_bcd;
  logic [0:0]  req_r_bcd;
  logic [1:0]  req_l_b, req_l_d;
  logic [2:0]  req_l_c;
  logic [0:0]  ack_r_b, ack_r_c, ack_r_d;
  logic [31:0] dout_b, dout_c, dout_d;
  logic [1:0]  level_b, level_c, level_d;

  async_operator_mcast #(.DATA_WIDTH(32), .OP(op_name_t'("addi")), .IMMEDIATE(32'd2),
    .INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a),
    .req_r(req_r_a), .ack_r(ack_r_a), .dout(dout_a), .level(level_a));

  async_operator_mcast #(.DATA_WIDTH(32), .OP(op_name_t'("add")), .IMMEDIATE(32'd0),
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .req_l(req_l_b), .ack_l(ack_bcd[1:0]), .din(din_bcd[63:0]),
    .req_r(req_r_bcd), .ack_r(ack_r_b), .dout(dout_b), .level(level_b));

  async_operator_mcast #(.DATA_WIDTH(32), .OP(op_name_t'("sub")), .IMMEDIATE(32'd0),
    .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .req_l(req_l_c), .ack_l(ack_bcd), .din(din_bcd),
    .req_r(req_r_bcd), .ack_r(ack_r_c), .dout(dout_c), .level(level_c));

  async_operator_mcast #(.DATA_WIDTH(32), .OP(op_name_t'("mul")), .IMMEDIATE(32'd0),
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2)) dut_d (
    .clk(clk), .rst(rst), .req_l(req_l_d), .ack_l(ack_bcd[1:0]), .din(din_bcd[63:0]),
    .req_r(req_r_bcd), .ack_r(ack_r_d), .dout(dout_d), .level(level_d));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted operand v yields v+2 for each consumer, in order.
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];
  int          ack_cnt0 = 0;
  int          ack_cnt1 = 0;
  logic [1:0]  ack_prev = 2'b00;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("a_level_bound", 64'(level_a <= 3'd4), 64'd1);
      if (ack_r_a[0]) begin
        ack_cnt0++;
        check("a_c0_no_b2b", 64'(ack_prev[0]), 64'd0);
        check("a_c0_ack_has_data", 64'(expq0.size() != 0), 64'd1);
        if (expq0.size() != 0) begin
          mon_exp = expq0.pop_front();
          check("a_c0_dout", 64'(dout_a[31:0]), 64'(mon_exp));
        end
      end
      if (ack_r_a[1]) begin
        ack_cnt1++;
        check("a_c1_no_b2b", 64'(ack_prev[1]), 64'd0);
        check("a_c1_ack_has_data", 64'(expq1.size() != 0), 64'd1);
        if (expq1.size() != 0) begin
          mon_exp = expq1.pop_front();
          check("a_c1_dout", 64'(dout_a[63:32]), 64'(mon_exp));
        end
      end
      ack_prev = ack_r_a;
    end else begin
      ack_prev = 2'b00;
    end
  end

  task automatic feed_a(input int n, input int max_cyc, input int pct, input bit rnd_val,
                        input logic [31:0] base, output int acc);
    logic [31:0] v;
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      @(negedge clk);
      ack_l_a = 1'b0;
      if (req_l_a[0] && ($urandom_range(99) < 32'(pct))) begin
        v = rnd_val ? $urandom : base + 32'(acc);
        din_a   = v;
        ack_l_a = 1'b1;
        expq0.push_back(v + 32'd2);
        expq1.push_back(v + 32'd2);
        acc++;
      end
    end
    @(negedge clk);
    ack_l_a = 1'b0;
  endtask

  task automatic drain_a(input int max_cyc);
    req_r_a = 2'b11;
    for (int c = 0; c < max_cyc && (expq0.size() != 0 || expq1.size() != 0); c++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("a_drain_q0_empty", 64'(expq0.size()), 64'd0);
    check("a_drain_q1_empty", 64'(expq1.size()), 64'd0);
    check("a_drain_level", 64'(level_a), 64'd0);
  endtask

  task automatic txn_bcd(input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input int dly);
    logic [31:0] eb, ec, ed;
    logic [2:0]  got;
    eb = x0 + x1;
    ec = x0 - x1 - x2;
    ed = x0 * x1;
    @(negedge clk);
    din_bcd = {x2, x1, x0};
    ack_bcd = 3'b001;
    @(negedge clk);
    ack_bcd = 3'b000;
    repeat (dly) @(negedge clk);
    check("b_req_l0_held", 64'(req_l_b[0]), 64'd0);
    check("b_req_l1_waiting", 64'(req_l_b[1]), 64'd1);
    ack_bcd = 3'b110;
    @(negedge clk);
    ack_bcd = 3'b000;
    got = 3'b000;
    for (int c = 0; c < 10 && got != 3'b111; c++) begin
      @(negedge clk);
      if (ack_r_b[0] && !got[0]) begin check("b_add_dout", 64'(dout_b), 64'(eb)); got[0] = 1'b1; end
      if (ack_r_c[0] && !got[1]) begin check("c_sub_dout", 64'(dout_c), 64'(ec)); got[1] = 1'b1; end
      if (ack_r_d[0] && !got[2]) begin check("d_mul_dout", 64'(dout_d), 64'(ed)); got[2] = 1'b1; end
    end
    check("bcd_acks_seen", 64'(got), 64'b111);
    check("b_req_l_rearmed", 64'(req_l_b), 64'b11);
    $display("txn bcd x0=%h x1=%h x2=%h dly=%0d add=%h sub=%h mul=%h", x0, x1, x2, dly, dout_b, dout_c, dout_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, n1;
    bit seen;
    rst = 1'b1; ack_l_a = '0; din_a = '0; req_r_a = '0;
    ack_bcd = '0; din_bcd = '0; req_r_bcd = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_l_a", 64'(req_l_a), 64'd0);
    check("rst_ack_r_a", 64'(ack_r_a), 64'd0);
    check("rst_level_a", 64'(level_a), 64'd0);
    check("rst_req_l_c", 64'(req_l_c), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("first_cycle_req_l_a", 64'(req_l_a), 64'd1);
    check("first_cycle_req_l_c", 64'(req_l_c), 64'b111);
    $display("txn reset release req_l_a=%b req_l_c=%b", req_l_a, req_l_c);

    // In-order stream 0..9 with both consumers always requesting
    req_r_a = 2'b11; n0 = ack_cnt0; n1 = ack_cnt1;
    feed_a(10, 200, 100, 1'b0, 32'd0, acc);
    check("stream_accepted", 64'(acc), 64'd10);
    drain_a(100);
    check("stream_c0_acks", 64'(ack_cnt0 - n0), 64'd10);
    check("stream_c1_acks", 64'(ack_cnt1 - n1), 64'd10);
    $display("txn stream 0..9 c0=%0d c1=%0d", ack_cnt0 - n0, ack_cnt1 - n1);

    // Full buffer: 4 stored plus one held in the operand slot
    req_r_a = 2'b00; n0 = ack_cnt0; n1 = ack_cnt1;
    feed_a(6, 30, 100, 1'b0, 32'd100, acc);
    check("full_accepted", 64'(acc), 64'd5);
    check("full_level", 64'(level_a), 64'd4);
    check("full_req_l_low", 64'(req_l_a), 64'd0);
    $display("txn full accepted=%0d level=%0d", acc, level_a);

    // Consumer1 stalled: consumer0 drains the 4 stored entries, then the buffer stays full
    req_r_a = 2'b01;
    repeat (20) @(negedge clk);
    check("stall_c0_acks", 64'(ack_cnt0 - n0), 64'd4);
    check("stall_c1_acks", 64'(ack_cnt1 - n1), 64'd0);
    check("stall_level", 64'(level_a), 64'd4);
    check("stall_req_l_low", 64'(req_l_a), 64'd0);
    req_r_a = 2'b11;
    feed_a(1, 50, 100, 1'b0, 32'd105, acc);
    drain_a(100);
    check("stall_c0_total", 64'(ack_cnt0 - n0), 64'd6);
    check("stall_c1_total", 64'(ack_cnt1 - n1), 64'd6);
    $display("txn stall release c0=%0d c1=%0d", ack_cnt0 - n0, ack_cnt1 - n1);

    // Random operands, random producer pacing, random consumer requests
    for (int ph = 0; ph < 3; ph++) begin
      n0 = ack_cnt0; n1 = ack_cnt1;
      fork
        feed_a(30, 300, 40 + 20 * ph, 1'b1, 32'd0, acc);
        begin
          for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            req_r_a = 2'($urandom_range(3));
          end
        end
      join
      drain_a(200);
      check("rand_c0_count", 64'(ack_cnt0 - n0), 64'(acc));
      check("rand_c1_count", 64'(ack_cnt1 - n1), 64'(acc));
      $display("txn random phase=%0d accepted=%0d", ph, acc);
    end

    // Arithmetic corners, including a delayed second operand
    txn_bcd(32'd7, 32'd9, 32'd0, 5);
    txn_bcd(32'hFFFF_FFFF, 32'd2, 32'd0, 0);
    txn_bcd(32'd3, 32'd5, 32'd0, 1);
    txn_bcd(32'h0001_0000, 32'h0001_0000, 32'd0, 2);
    for (int k = 0; k < 4; k++) txn_bcd($urandom, $urandom, $urandom, int'($urandom_range(4)));

    // Reset mid-operation: 3 buffered, one ack in flight, one partial operand set
    req_r_a = 2'b00;
    feed_a(3, 30, 100, 1'b0, 32'd200, acc);
    repeat (3) @(negedge clk);
    check("prerst_level", 64'(level_a), 64'd3);
    din_bcd = {32'd0, 32'd0, 32'hDEAD};
    ack_bcd = 3'b001;
    @(negedge clk);
    ack_bcd = 3'b000;
    req_r_a = 2'b01;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ack_r_a[0];
    end
    check("prerst_ack_seen", 64'(seen), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ack_r", 64'(ack_r_a), 64'd0);
    check("rst_async_level", 64'(level_a), 64'd0);
    check("rst_async_req_l", 64'(req_l_a), 64'd0);
    expq0.delete();
    expq1.delete();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_req_l_a", 64'(req_l_a), 64'd1);
    check("postrst_req_l_c", 64'(req_l_c), 64'b111);
    n0 = ack_cnt0; n1 = ack_cnt1;
    req_r_a = 2'b11;
    repeat (10) @(negedge clk);
    check("postrst_no_ack_c0", 64'(ack_cnt0 - n0), 64'd0);
    check("postrst_no_ack_c1", 64'(ack_cnt1 - n1), 64'd0);
    $display("txn reset mid-operation level=%0d", level_a);
    txn_bcd(32'd5, 32'd3, 32'd1, 0);
    feed_a(2, 50, 100, 1'b0, 32'd300, acc);
    drain_a(100);
    check("postrst_c0_acks", 64'(ack_cnt0 - n0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
